// File: rtl/gf180mcu_ef_io_bi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gf180mcu_ef_io_bi_ctrl
// Brief    : Core-side controller for one bidirectional GF180 pad: break-
//            before-make config sequencer, output register, input sync/filter.
// Revision : 1.0
// ============================================================================
module gf180mcu_ef_io_bi_ctrl #(
  parameter int TURN_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 3,
  parameter int DEB_CYCLES    = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CFG_VALID,
  output logic       CFG_READY,
  input  logic [7:0] CFG_DATA,
  output logic       CFG_DONE,
  output logic       CFG_ERR,
  output logic [1:0] CUR_MODE,
  input  logic       DOUT,
  output logic       DIN,
  output logic       DIN_EDGE,
  output logic       CS,
  output logic       SL,
  output logic       IE,
  output logic       OE,
  output logic       PU,
  output logic       PD,
  output logic       A,
  output logic       PDRV0,
  output logic       PDRV1,
  input  logic       Y
);

  localparam int c_SEQ_MAX = (TURN_CYCLES > SETTLE_CYCLES) ? TURN_CYCLES : SETTLE_CYCLES;
  localparam int c_SEQ_W   = (c_SEQ_MAX > 1) ? $clog2(c_SEQ_MAX) : 1;
  localparam int c_DEB_W   = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;

  localparam logic [c_SEQ_W-1:0] c_TURN_LOAD   = c_SEQ_W'(TURN_CYCLES - 1);
  localparam logic [c_SEQ_W-1:0] c_SETTLE_LOAD = c_SEQ_W'(SETTLE_CYCLES - 1);
  localparam logic [c_SEQ_W-1:0] c_SEQ_ONE     = c_SEQ_W'(1);
  localparam logic [c_DEB_W-1:0] c_DEB_MAX     = c_DEB_W'(DEB_CYCLES);
  localparam logic [c_DEB_W-1:0] c_DEB_ONE     = c_DEB_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REJECT  = 2'd1,
    TURNOFF = 2'd2,
    SETTLE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_start;
  logic                 w_reject;
  logic                 w_load_static;
  logic                 w_apply_oe;
  logic [c_SEQ_W-1:0]   r_seq_cnt;
  logic [7:0]           r_cfg;

  logic                 r_cs;
  logic                 r_sl;
  logic                 r_ie;
  logic                 r_oe;
  logic                 r_pu;
  logic                 r_pd;
  logic [1:0]           r_pdrv;
  logic [1:0]           r_mode;
  logic                 r_a;
  logic                 r_done;
  logic                 r_err;

  logic                 r_s1;
  logic                 r_s2;
  logic                 r_din;
  logic                 r_din_edge;
  logic [c_DEB_W-1:0]   r_deb_cnt;

  // --------------------------------------------------------------------------
  // Sequencer state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_start       = 1'b0;
    w_reject      = 1'b0;
    w_load_static = 1'b0;
    w_apply_oe    = 1'b0;
    case (r_state)
      IDLE: begin
        if (CFG_VALID) begin
          if (CFG_DATA[2] && CFG_DATA[3]) begin
            w_state_nxt = REJECT;
            w_reject    = 1'b1;
          end else begin
            w_state_nxt = TURNOFF;
            w_start     = 1'b1;
          end
        end
      end
      REJECT: begin
        w_state_nxt = IDLE;
      end
      TURNOFF: begin
        if (r_seq_cnt == '0) begin
          w_state_nxt   = SETTLE;
          w_load_static = 1'b1;
        end
      end
      SETTLE: begin
        if (r_seq_cnt == '0) begin
          w_state_nxt = IDLE;
          w_apply_oe  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Pad control registers; OE drops on accept and only returns once the
  // static controls have had SETTLE_CYCLES to take effect.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_seq_cnt <= '0;
      r_cfg     <= '0;
      r_cs      <= 1'b0;
      r_sl      <= 1'b0;
      r_ie      <= 1'b0;
      r_oe      <= 1'b0;
      r_pu      <= 1'b0;
      r_pd      <= 1'b0;
      r_pdrv    <= 2'b00;
      r_mode    <= 2'b00;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= w_apply_oe;
      r_err  <= w_reject;
      if (w_start) begin
        r_cfg     <= CFG_DATA;
        r_oe      <= 1'b0;
        r_seq_cnt <= c_TURN_LOAD;
      end else if (w_load_static) begin
        r_mode    <= r_cfg[1:0];
        r_ie      <= r_cfg[0];
        r_pu      <= r_cfg[2];
        r_pd      <= r_cfg[3];
        r_cs      <= r_cfg[4];
        r_sl      <= r_cfg[5];
        r_pdrv    <= r_cfg[7:6];
        r_seq_cnt <= c_SETTLE_LOAD;
      end else if (w_apply_oe) begin
        r_oe      <= r_cfg[1];
      end else if (r_state == TURNOFF || r_state == SETTLE) begin
        r_seq_cnt <= r_seq_cnt - c_SEQ_ONE;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_a <= 1'b0;
    end else begin
      r_a <= DOUT;
    end
  end

  // --------------------------------------------------------------------------
  // Input path: gated 2-flop synchronizer followed by a persistence filter.
  // The counter saturates at DEB_CYCLES by construction, so it never wraps.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_din      <= 1'b0;
      r_din_edge <= 1'b0;
      r_deb_cnt  <= '0;
    end else begin
      r_s1       <= Y & r_ie;
      r_s2       <= r_s1;
      r_din_edge <= 1'b0;
      if (r_s2 != r_din) begin
        if (r_deb_cnt == c_DEB_MAX) begin
          r_din      <= r_s2;
          r_deb_cnt  <= '0;
          r_din_edge <= 1'b1;
        end else begin
          r_deb_cnt  <= r_deb_cnt + c_DEB_ONE;
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

  assign CFG_READY = (r_state == IDLE);
  assign CFG_DONE  = r_done;
  assign CFG_ERR   = r_err;
  assign CUR_MODE  = r_mode;
  assign DIN       = r_din;
  assign DIN_EDGE  = r_din_edge;
  assign CS        = r_cs;
  assign SL        = r_sl;
  assign IE        = r_ie;
  assign OE        = r_oe;
  assign PU        = r_pu;
  assign PD        = r_pd;
  assign A         = r_a;
  assign PDRV0     = r_pdrv[0];
  assign PDRV1     = r_pdrv[1];

endmodule
`default_nettype wire
